// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receiver: deglitched line sampling, 11-bit frame reception with
// odd-parity/stop checks, 3-byte packet alignment and a clamped cursor position.
`timescale 1ns/1ps
module ps2_mouse_packet_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int INHIBIT_CYC = 10000,
  parameter int POS_W       = 10,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240
) (
  input  logic             iClk,
  input  logic             iRst_n,
  inout  wire              ioPs2Clk,
  inout  wire              ioPs2Data,
  output logic             oPktValid,
  output logic [2:0]       oBtn,
  output logic [8:0]       oDx,
  output logic [8:0]       oDy,
  output logic [1:0]       oOvf,
  output logic [POS_W-1:0] oPosX,
  output logic [POS_W-1:0] oPosY,
  output logic             oParityErr,
  output logic             oFrameErr,
  output logic             oInhibit
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int PW = POS_W + 2;
  localparam logic signed [PW-1:0] XMAX_S = PW'(X_MAX);
  localparam logic signed [PW-1:0] YMAX_S = PW'(Y_MAX);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_INHIBIT} state_t;
  state_t r_state, w_stateNxt;

  logic [1:0]          r_clkSync, r_datSync;
  logic                r_clkFilt, r_clkPrev, r_datFilt;
  logic [FW-1:0]       r_clkCnt, r_datCnt;
  logic [3:0]          r_bitCnt;
  logic [7:0]          r_shift;
  logic [TW-1:0]       r_toCnt;
  logic [IW-1:0]       r_inhCnt;
  logic [1:0]          r_idx;
  logic [2:0]          r_btn0;
  logic                r_xSign, r_ySign, r_xOvf, r_yOvf;
  logic [7:0]          r_xByte;
  logic                w_fe, w_inhExit, w_toHit, w_accept, w_parErr, w_frmErr;
  logic signed [PW-1:0] w_dx, w_dy, w_xSum, w_ySum;
  logic [POS_W-1:0]    w_xNext, w_yNext;

  // The bus is only ever pulled low; the pull-up supplies the high level.
  assign oInhibit  = (r_state == S_INHIBIT);
  assign ioPs2Clk  = oInhibit ? 1'b0 : 1'bz;
  assign ioPs2Data = 1'bz;

  assign w_fe      = r_clkPrev & ~r_clkFilt;
  assign w_inhExit = oInhibit && (r_inhCnt == IW'(INHIBIT_CYC - 1));
  assign w_toHit   = (r_toCnt == TW'(TIMEOUT_CYC - 1)) && !w_fe;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_clkSync <= 2'b11;
      r_datSync <= 2'b11;
    end else begin
      r_clkSync <= {r_clkSync[0], ioPs2Clk};
      r_datSync <= {r_datSync[0], ioPs2Data};
    end
  end

  // Filtered levels follow the line only after FILTER_LEN agreeing samples;
  // leaving inhibit snaps them to the line so no false edge is produced.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_clkFilt <= 1'b1;
      r_clkPrev <= 1'b1;
      r_datFilt <= 1'b1;
      r_clkCnt  <= '0;
      r_datCnt  <= '0;
    end else if (w_inhExit) begin
      r_clkFilt <= r_clkSync[1];
      r_clkPrev <= r_clkSync[1];
      r_datFilt <= r_datSync[1];
      r_clkCnt  <= '0;
      r_datCnt  <= '0;
    end else begin
      r_clkPrev <= r_clkFilt;
      if (r_clkSync[1] == r_clkFilt) r_clkCnt <= '0;
      else if (r_clkCnt == FW'(FILTER_LEN - 1)) begin
        r_clkFilt <= r_clkSync[1];
        r_clkCnt  <= '0;
      end else r_clkCnt <= r_clkCnt + 1'b1;
      if (r_datSync[1] == r_datFilt) r_datCnt <= '0;
      else if (r_datCnt == FW'(FILTER_LEN - 1)) begin
        r_datFilt <= r_datSync[1];
        r_datCnt  <= '0;
      end else r_datCnt <= r_datCnt + 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_state <= S_IDLE;
    else         r_state <= w_stateNxt;
  end

  always_comb begin
    w_stateNxt = r_state;
    w_accept   = 1'b0;
    w_parErr   = 1'b0;
    w_frmErr   = 1'b0;
    case (r_state)
      S_IDLE: if (w_fe && !r_datFilt) w_stateNxt = S_RECV;
      S_RECV: begin
        if (w_fe) begin
          if (r_bitCnt == 4'd8 && !(^r_shift ^ r_datFilt)) begin
            w_parErr   = 1'b1;
            w_stateNxt = S_INHIBIT;
          end else if (r_bitCnt == 4'd9) begin
            if (!r_datFilt) begin
              w_frmErr   = 1'b1;
              w_stateNxt = S_INHIBIT;
            end else begin
              w_accept   = 1'b1;
              w_stateNxt = S_IDLE;
            end
          end
        end else if (w_toHit) begin
          w_frmErr   = 1'b1;
          w_stateNxt = S_IDLE;
        end
      end
      S_INHIBIT: if (w_inhExit) w_stateNxt = S_IDLE;
      default:   w_stateNxt = S_IDLE;
    endcase
  end

  // One shared idle counter serves both the in-frame and between-byte timeouts.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_toCnt  <= '0;
      r_inhCnt <= '0;
    end else begin
      if (r_state != S_RECV) r_bitCnt <= '0;
      else if (w_fe) begin
        if (r_bitCnt < 4'd8) r_shift <= {r_datFilt, r_shift[7:1]};
        r_bitCnt <= r_bitCnt + 4'd1;
      end
      r_toCnt  <= (oInhibit || w_fe || w_toHit) ? '0 : r_toCnt + 1'b1;
      r_inhCnt <= (oInhibit && !w_inhExit) ? r_inhCnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_dx    = r_xOvf ? '0 : {{(PW-8){r_xSign}}, r_xByte};
    w_dy    = r_yOvf ? '0 : {{(PW-8){r_ySign}}, r_shift};
    w_xSum  = $signed({2'b00, oPosX}) + w_dx;
    w_ySum  = $signed({2'b00, oPosY}) - w_dy;
    w_xNext = w_xSum[POS_W-1:0];
    w_yNext = w_ySum[POS_W-1:0];
    if (w_xSum[PW-1])         w_xNext = '0;
    else if (w_xSum > XMAX_S) w_xNext = POS_W'(X_MAX);
    if (w_ySum[PW-1])         w_yNext = '0;
    else if (w_ySum > YMAX_S) w_yNext = POS_W'(Y_MAX);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_idx      <= '0;
      r_btn0     <= '0;
      r_xSign    <= 1'b0;
      r_ySign    <= 1'b0;
      r_xOvf     <= 1'b0;
      r_yOvf     <= 1'b0;
      r_xByte    <= '0;
      oPktValid  <= 1'b0;
      oParityErr <= 1'b0;
      oFrameErr  <= 1'b0;
      oBtn       <= '0;
      oDx        <= '0;
      oDy        <= '0;
      oOvf       <= '0;
      oPosX      <= POS_W'(X_INIT);
      oPosY      <= POS_W'(Y_INIT);
    end else begin
      oPktValid  <= w_accept && (r_idx == 2'd2);
      oParityErr <= w_parErr;
      oFrameErr  <= w_frmErr;
      if (w_parErr || w_frmErr || (w_toHit && r_state == S_IDLE)) r_idx <= '0;
      else if (w_accept) begin
        case (r_idx)
          2'd0: if (r_shift[3]) begin
            r_idx   <= 2'd1;
            r_btn0  <= r_shift[2:0];
            r_xSign <= r_shift[4];
            r_ySign <= r_shift[5];
            r_xOvf  <= r_shift[6];
            r_yOvf  <= r_shift[7];
          end
          2'd1: begin
            r_idx   <= 2'd2;
            r_xByte <= r_shift;
          end
          default: begin
            r_idx <= '0;
            oBtn  <= r_btn0;
            oDx   <= {r_xSign, r_xByte};
            oDy   <= {r_ySign, r_shift};
            oOvf  <= {r_yOvf, r_xOvf};
            oPosX <= w_xNext;
            oPosY <= w_yNext;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Bench for ps2_mouse_packet_rx: a bit-level PS/2 device drives directed packets
// and a packet-level model predicts the decoded fields and cursor position.
`timescale 1ns/1ps
module tb_ps2_mouse_packet_rx;
  localparam int TO   = 2000;
  localparam int INH  = 500;
  localparam int XMAX = 639;
  localparam int YMAX = 479;

  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  logic devClkLow = 1'b0;
  logic devDataLow = 1'b0;
  wire  ps2Clk, ps2Data;

  pullup (ps2Clk);
  pullup (ps2Data);
  assign ps2Clk  = devClkLow  ? 1'b0 : 1'bz;
  assign ps2Data = devDataLow ? 1'b0 : 1'bz;

  logic       oPktValid, oParityErr, oFrameErr, oInhibit;
  logic [2:0] oBtn;
  logic [8:0] oDx, oDy;
  logic [1:0] oOvf;
  logic [9:0] oPosX, oPosY;

  ps2_mouse_packet_rx #(
    .FILTER_LEN(8), .TIMEOUT_CYC(TO), .INHIBIT_CYC(INH), .POS_W(10),
    .X_MAX(XMAX), .Y_MAX(YMAX), .X_INIT(320), .Y_INIT(240)
  ) dut (
    .iClk(iClk), .iRst_n(iRst_n), .ioPs2Clk(ps2Clk), .ioPs2Data(ps2Data),
    .oPktValid(oPktValid), .oBtn(oBtn), .oDx(oDx), .oDy(oDy), .oOvf(oOvf),
    .oPosX(oPosX), .oPosY(oPosY), .oParityErr(oParityErr),
    .oFrameErr(oFrameErr), .oInhibit(oInhibit)
  );

  always #5 iClk = ~iClk;

  int checks = 0, errors = 0;
  int pktSeen = 0, parSeen = 0, frmSeen = 0, inhCycles = 0, inhLineBad = 0;
  logic [23:0] expQ[$];
  int mX = 320, mY = 240;
  logic [2:0] mBtn = '0;
  logic [8:0] mDx = '0, mDy = '0;
  logic [1:0] mOvf = '0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  function automatic int clampI(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic modelApply(input logic [23:0] p);
    logic [7:0] b0, b1, b2;
    int dx, dy;
    b0 = p[23:16];
    b1 = p[15:8];
    b2 = p[7:0];
    dx = b0[4] ? int'(b1) - 256 : int'(b1);
    dy = b0[5] ? int'(b2) - 256 : int'(b2);
    if (b0[6]) dx = 0;
    if (b0[7]) dy = 0;
    mX   = clampI(mX + dx, XMAX);
    mY   = clampI(mY - dy, YMAX);
    mBtn = b0[2:0];
    mDx  = {b0[4], b1};
    mDy  = {b0[5], b2};
    mOvf = {b0[7], b0[6]};
  endtask

  // Every accepted packet is matched against the next expected one.
  always @(negedge iClk) begin
    if (oPktValid) begin
      pktSeen++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedPkt: got pktValid=1 with dx=0x%0h, expected no packet", oDx);
      end else begin
        modelApply(expQ.pop_front());
        checkOutput("pktBtn", int'(oBtn), int'(mBtn));
        checkOutput("pktDx", int'(oDx), int'(mDx));
        checkOutput("pktDy", int'(oDy), int'(mDy));
        checkOutput("pktOvf", int'(oOvf), int'(mOvf));
        checkOutput("pktPosX", int'(oPosX), mX);
        checkOutput("pktPosY", int'(oPosY), mY);
      end
    end
    if (oParityErr) parSeen++;
    if (oFrameErr) frmSeen++;
    if (oInhibit) begin
      inhCycles++;
      if (ps2Clk !== 1'b0) inhLineBad++;
    end
  end

  // mode: 0 clean, 1 bad parity, 2 clock glitch inside bit 3, 3 stall after 5 bits
  task automatic applyStimulus(input logic [7:0] b, input int mode);
    logic [10:0] bits;
    logic par;
    par = ~(^b);
    if (mode == 1) par = ~par;
    bits = {1'b1, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (mode == 3 && i == 5) begin
        devDataLow = 1'b0;
        repeat (TO + 500) @(posedge iClk);
        break;
      end
      devDataLow = ~bits[i];
      repeat (20) @(posedge iClk);
      devClkLow = 1'b1;
      repeat (40) @(posedge iClk);
      devClkLow = 1'b0;
      if (mode == 2 && i == 3) begin
        repeat (8) @(posedge iClk);
        devClkLow = 1'b1;
        repeat (3) @(posedge iClk);
        devClkLow = 1'b0;
        repeat (9) @(posedge iClk);
      end else begin
        repeat (20) @(posedge iClk);
      end
    end
    devDataLow = 1'b0;
    repeat (100) @(posedge iClk);
  endtask

  task automatic sendPacket(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int mode1);
    expQ.push_back({b0, b1, b2});
    applyStimulus(b0, 0);
    applyStimulus(b1, mode1);
    applyStimulus(b2, 0);
  endtask

  task automatic doReset();
    iRst_n = 1'b0;
    expQ.delete();
    mX = 320; mY = 240; mBtn = '0; mDx = '0; mDy = '0; mOvf = '0;
    repeat (3) @(negedge iClk);
    checkOutput("rstPktValid", int'(oPktValid), 0);
    checkOutput("rstBtn", int'(oBtn), 0);
    checkOutput("rstDx", int'(oDx), 0);
    checkOutput("rstDy", int'(oDy), 0);
    checkOutput("rstOvf", int'(oOvf), 0);
    checkOutput("rstPosX", int'(oPosX), 320);
    checkOutput("rstPosY", int'(oPosY), 240);
    checkOutput("rstErrs", int'({oParityErr, oFrameErr, oInhibit}), 0);
    checkOutput("rstBusReleased", (ps2Clk === 1'b1) ? 1 : 0, 1);
    @(posedge iClk);
    #1 iRst_n = 1'b1;
    repeat (20) @(posedge iClk);
  endtask

  initial begin
    int p0, q0, f0, i0;
    doReset();

    p0 = pktSeen;
    sendPacket(8'h08, 8'h05, 8'h03, 0);
    checkOutput("s1Pkts", pktSeen - p0, 1);
    checkOutput("s1Btn", int'(oBtn), 0);
    checkOutput("s1Dx", int'(oDx), 'h005);
    checkOutput("s1Dy", int'(oDy), 'h003);
    checkOutput("s1PosX", int'(oPosX), 325);
    checkOutput("s1PosY", int'(oPosY), 237);

    doReset();
    p0 = pktSeen;
    sendPacket(8'h19, 8'hFB, 8'h00, 0);
    checkOutput("s2Pkts", pktSeen - p0, 1);
    checkOutput("s2Btn", int'(oBtn), 1);
    checkOutput("s2Dx", int'(oDx), 'h1FB);
    checkOutput("s2PosX", int'(oPosX), 315);
    checkOutput("s2PosY", int'(oPosY), 240);

    p0 = pktSeen; q0 = parSeen; i0 = inhCycles;
    applyStimulus(8'h08, 0);
    applyStimulus(8'h05, 1);
    for (int k = 0; k < 4 * INH && oInhibit; k++) @(negedge iClk);
    checkOutput("s3InhibitEnds", int'(oInhibit), 0);
    repeat (50) @(posedge iClk);
    checkOutput("s3ParErr", parSeen - q0, 1);
    checkOutput("s3InhCycles", inhCycles - i0, INH);
    checkOutput("s3InhLineLow", inhLineBad, 0);
    checkOutput("s3NoPkt", pktSeen - p0, 0);
    sendPacket(8'h08, 8'h05, 8'h03, 0);
    checkOutput("s3Pkts", pktSeen - p0, 1);
    checkOutput("s3PosX", int'(oPosX), 320);
    checkOutput("s3PosY", int'(oPosY), 237);

    p0 = pktSeen;
    applyStimulus(8'h00, 0);
    sendPacket(8'h08, 8'h0A, 8'h00, 0);
    checkOutput("s4Pkts", pktSeen - p0, 1);
    checkOutput("s4PosX", int'(oPosX), 330);

    sendPacket(8'h08, 8'hFF, 8'h00, 0);
    sendPacket(8'h08, 8'h32, 8'h00, 0);
    checkOutput("s5Start635", int'(oPosX), 635);
    sendPacket(8'h08, 8'h64, 8'h00, 0);
    checkOutput("s5ClampHi", int'(oPosX), 639);
    sendPacket(8'h18, 8'hFC, 8'h00, 0);
    checkOutput("s5Back635", int'(oPosX), 635);
    sendPacket(8'h48, 8'h64, 8'h00, 0);
    checkOutput("s5OvfPosX", int'(oPosX), 635);
    checkOutput("s5OvfBits", int'(oOvf), 1);
    checkOutput("s5OvfRawDx", int'(oDx), 'h064);
    sendPacket(8'h08, 8'h00, 8'hFF, 0);
    checkOutput("s5ClampYLo", int'(oPosY), 0);

    p0 = pktSeen; f0 = frmSeen; i0 = inhCycles;
    applyStimulus(8'h08, 3);
    checkOutput("s6FrameErr", frmSeen - f0, 1);
    checkOutput("s6NoInhibit", inhCycles - i0, 0);
    sendPacket(8'h08, 8'h05, 8'h03, 0);
    checkOutput("s6Pkts", pktSeen - p0, 1);
    checkOutput("s6PosX", int'(oPosX), 639);
    checkOutput("s6PosY", int'(oPosY), 0);

    p0 = pktSeen;
    sendPacket(8'h18, 8'hF6, 8'h00, 2);
    checkOutput("s7GlitchPkts", pktSeen - p0, 1);
    checkOutput("s7GlitchDx", int'(oDx), 'h1F6);
    checkOutput("s7GlitchPosX", int'(oPosX), 629);

    p0 = pktSeen; f0 = frmSeen;
    applyStimulus(8'h08, 0);
    repeat (TO + 500) @(posedge iClk);
    sendPacket(8'h18, 8'hF6, 8'h00, 0);
    checkOutput("s8Pkts", pktSeen - p0, 1);
    checkOutput("s8NoFrameErr", frmSeen - f0, 0);
    checkOutput("s8PosX", int'(oPosX), 619);
    checkOutput("s8QueueEmpty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("[TB] FAIL watchdog: got simulation time limit reached, expected bench completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
